// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and constants for the two-requester ALU sharing controller.
package alu_share_ctrl_pkg;

  localparam int FLAG_W = 3;
  localparam int FLAG_N = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SHL = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_NOT = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // On a tie the requester that did not win last time is chosen.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_id);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last_id ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves on a completed handshake.
module rr_arb2
  import alu_share_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_id;

  assign grant = rr_pick(req, last_id);

  // Reset as if requester 1 won last, so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= 1'b1;
    end else if (advance) begin
      last_id <= grant[1];
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters with per-requester flag contexts.
//  state | meaning
//  IDLE  | no op in flight, accepting requests
//  EXEC  | ALU evaluating registered operands, results captured at end of cycle
//  RESP  | response held valid until rsp_ready; may accept next request
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_in1,
  input  logic [2*DATA_W-1:0] req_in2,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [1:0]          req_setflg,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [FLAG_W-1:0]   rsp_flag,
  output logic [FLAG_W-1:0]   flags0,
  output logic [FLAG_W-1:0]   flags1,
  output logic [DATA_W-1:0]   alu_in1,
  output logic [DATA_W-1:0]   alu_in2,
  output logic [OP_W-1:0]     alu_op,
  output logic [FLAG_W-1:0]   alu_flag_in,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic [FLAG_W-1:0]   alu_flag
);

  state_t     state, state_nxt;
  logic [1:0] grant;
  logic       accept;
  logic       req_fire;
  logic       lat_id;
  logic       lat_setflg;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (req_fire),
    .grant   (grant)
  );

  assign req_ready   = {2{accept}} & grant;
  assign req_fire    = accept & (|grant);
  assign rsp_valid   = (state == ST_RESP);
  assign alu_flag_in = lat_id ? flags1 : flags0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = 1'b1;
        if (|grant) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          accept    = 1'b1;
          state_nxt = (|grant) ? ST_EXEC : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= '0;
      lat_id     <= 1'b0;
      lat_setflg <= 1'b0;
    end else if (req_fire) begin
      alu_in1    <= grant[1] ? req_in1[2*DATA_W-1:DATA_W] : req_in1[DATA_W-1:0];
      alu_in2    <= grant[1] ? req_in2[2*DATA_W-1:DATA_W] : req_in2[DATA_W-1:0];
      alu_op     <= grant[1] ? req_op[2*OP_W-1:OP_W]      : req_op[OP_W-1:0];
      lat_id     <= grant[1];
      lat_setflg <= grant[1] ? req_setflg[1] : req_setflg[0];
    end
  end

  // Flag commit shares the EXEC edge with result capture, so the next op's
  // alu_flag_in already sees it (RESP always sits in between).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_flag <= '0;
      flags0   <= '0;
      flags1   <= '0;
    end else if (state == ST_EXEC) begin
      rsp_id   <= lat_id;
      rsp_data <= alu_out;
      rsp_flag <= alu_flag;
      if (lat_setflg) begin
        if (lat_id) flags1 <= alu_flag;
        else        flags0 <= alu_flag;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU and transaction model.
module tb_alu_share_ctrl;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_in1;
  logic [31:0] req_in2;
  logic [5:0]  req_op;
  logic [1:0]  req_setflg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flag;
  logic [2:0]  flags0;
  logic [2:0]  flags1;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [2:0]  alu_op;
  logic [2:0]  alu_flag_in;
  logic [15:0] alu_out;
  logic [2:0]  alu_flag;

  int checks = 0;
  int errors = 0;

  alu_share_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_in1     (req_in1),
    .req_in2     (req_in2),
    .req_op      (req_op),
    .req_setflg  (req_setflg),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_flag    (rsp_flag),
    .flags0      (flags0),
    .flags1      (flags1),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_op      (alu_op),
    .alu_flag_in (alu_flag_in),
    .alu_out     (alu_out),
    .alu_flag    (alu_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU stand-in: returns {Z,V,N,result}; logic ops keep V from FLAG_in.
  function automatic logic [18:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [2:0] fin);
    logic [15:0] r;
    logic        v;
    v = fin[1];
    r = '0;
    case (op)
      3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = a << b[3:0];
      3'd5: r = a >> b[3:0];
      3'd6: r = ~a;
      default: r = a & b;
    endcase
    return {(r == 16'h0), v, r[15], r};
  endfunction

  assign {alu_flag, alu_out} = alu_fn(alu_op, alu_in1, alu_in2, alu_flag_in);

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_in1    = '0;
    req_in2    = '0;
    req_op     = '0;
    req_setflg = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic sf);
    req_in1[id*16 +: 16] = a;
    req_in2[id*16 +: 16] = b;
    req_op[id*3 +: 3]    = op;
    req_setflg[id]       = sf;
    req_valid[id]        = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if ({flags1, flags0} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {flags1, flags0}); end
    checks++; if ({alu_in1, alu_in2, alu_op} !== 35'b0) begin errors++; $display("FAIL reset_alu_regs got %h %h %h exp 0", alu_in1, alu_in2, alu_op); end
    checks++; if ({rsp_id, rsp_data, rsp_flag} !== 20'b0) begin errors++; $display("FAIL reset_rsp_regs got %b %h %b exp 0", rsp_id, rsp_data, rsp_flag); end
    set_req(0, OP_ADD, 16'h7FFF, 16'h0001, 1'b1);
    set_req(1, OP_ADD, 16'h0002, 16'h0003, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL first_tie got %b exp 01", req_ready); end
    req_valid = 2'b01;
    @(negedge clk);
    #1;
    checks++; if (alu_in1 !== 16'h7FFF) begin errors++; $display("FAIL latch_in1 got %h exp 7fff", alu_in1); end
    rst_n     = 1'b0;
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 1'b0 || flags0 !== 3'b000) begin errors++; $display("FAIL reset_mid_exec got %b %b exp 0 000", rsp_valid, flags0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0 || flags0 !== 3'b000) begin errors++; $display("FAIL after_mid_reset got %b %b exp 0 000", rsp_valid, flags0); end
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL idle_after_reset got %b exp 10", req_ready); end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_add_overflow();
    do_reset();
    set_req(0, OP_ADD, 16'h7FFF, 16'h0001, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ovf_ready got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ovf_exec_valid got %b exp 0", rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h8000 || rsp_id !== 1'b0 || rsp_flag !== 3'b011)
      begin errors++; $display("FAIL ovf_rsp got %b %h %b %b exp 1 8000 0 011", rsp_valid, rsp_data, rsp_id, rsp_flag); end
    checks++; if (flags0 !== 3'b011 || flags1 !== 3'b000) begin errors++; $display("FAIL ovf_flags got %b %b exp 011 000", flags0, flags1); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_arbitration();
    int ngr;
    int exp_g;
    do_reset();
    set_req(0, OP_SUB, 16'h0005, 16'h0005, 1'b1);
    set_req(1, OP_XOR, 16'hA5A5, 16'h0F0F, 1'b0);
    ngr   = 0;
    exp_g = 0;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      #1;
      if (rsp_valid) begin
        checks++;
        if (rsp_id == 1'b0 && (rsp_data !== 16'h0000 || rsp_flag !== 3'b100)) begin
          errors++; $display("FAIL arb_rsp0 got %h %b exp 0000 100", rsp_data, rsp_flag);
        end else if (rsp_id == 1'b1 && (rsp_data !== 16'hAAAA || rsp_flag !== 3'b001)) begin
          errors++; $display("FAIL arb_rsp1 got %h %b exp aaaa 001", rsp_data, rsp_flag);
        end
      end
      if (req_ready != 2'b00) begin
        checks++;
        if (req_ready !== (2'b01 << exp_g)) begin
          errors++; $display("FAIL arb_grant%0d got %b exp %b", ngr, req_ready, 2'b01 << exp_g);
        end
        ngr++;
        exp_g ^= 1;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    checks++; if (ngr != 4) begin errors++; $display("FAIL arb_timeout got %0d grants exp 4", ngr); end
    repeat (3) @(negedge clk);
    checks++; if (flags0 !== 3'b100 || flags1 !== 3'b000) begin errors++; $display("FAIL arb_flags got %b %b exp 100 000", flags0, flags1); end
  endtask

  task automatic test_stall();
    do_reset();
    set_req(0, OP_ADD, 16'h1234, 16'h1111, 1'b0);
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_first got %b exp 01", req_ready); end
    @(negedge clk);
    set_req(1, OP_OR, 16'h00F0, 16'h0F00, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_exec_ready got %b exp 00", req_ready); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h2345 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
        errors++; $display("FAIL stall_hold%0d got %b %h %b %b exp 1 2345 0 00", i, rsp_valid, rsp_data, rsp_id, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10 || rsp_data !== 16'h2345) begin errors++; $display("FAIL stall_release got %b %h exp 10 2345", req_ready, rsp_data); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_b2b_exec got %b exp 0", rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0FF0 || rsp_id !== 1'b1) begin errors++; $display("FAIL stall_second got %b %h %b exp 1 0ff0 1", rsp_valid, rsp_data, rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_setflg0();
    do_reset();
    set_req(1, OP_ADD, 16'h0001, 16'hFFFF, 1'b0);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL nsf_ready got %b exp 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    checks++; if (rsp_data !== 16'h0000 || rsp_flag !== 3'b100 || rsp_id !== 1'b1) begin errors++; $display("FAIL nsf_rsp got %h %b %b exp 0000 100 1", rsp_data, rsp_flag, rsp_id); end
    checks++; if (flags1 !== 3'b000 || flags0 !== 3'b000) begin errors++; $display("FAIL nsf_flags got %b %b exp 000 000", flags1, flags0); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, OP_SUB, 16'h0003, 16'h0005, 1'b1);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_first got %b exp 01", req_ready); end
    @(negedge clk);
    set_req(0, OP_ADD, 16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    #1;
    checks++; if (rsp_data !== 16'hFFFE || flags0 !== 3'b001 || req_ready !== 2'b01) begin errors++; $display("FAIL b2b_resp got %h %b %b exp fffe 001 01", rsp_data, flags0, req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++; if (alu_flag_in !== 3'b001 || alu_op !== OP_ADD) begin errors++; $display("FAIL b2b_flag_in got %b %b exp 001 000", alu_flag_in, alu_op); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0002 || rsp_flag !== 3'b000) begin errors++; $display("FAIL b2b_second got %b %h %b exp 1 0002 000", rsp_valid, rsp_data, rsp_flag); end
    @(negedge clk);
  endtask

  // Transaction-level model: one op in flight, response two cycles after accept,
  // ties alternate, flag context committed per op.
  task automatic test_random();
    int          m_last;
    bit          outst;
    int          acc_cyc;
    int          g;
    logic        exp_rv;
    logic        acc;
    logic [1:0]  exp_rr;
    logic [15:0] e_data;
    logic [2:0]  e_flag;
    logic        e_id;
    logic [2:0]  ctx [2];
    logic [18:0] res;
    do_reset();
    m_last  = 1;
    outst   = 0;
    acc_cyc = 0;
    e_data  = '0;
    e_flag  = '0;
    e_id    = 1'b0;
    ctx[0]  = '0;
    ctx[1]  = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid  = 2'($urandom_range(0, 3));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      req_in1    = $urandom;
      req_in2    = ($urandom_range(0, 3) == 0) ? req_in1 : $urandom;
      req_op     = 6'($urandom);
      req_setflg = 2'($urandom);
      #1;
      exp_rv = outst && (cyc - acc_cyc >= 2);
      checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", cyc, rsp_valid, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (rsp_data !== e_data || rsp_flag !== e_flag || rsp_id !== e_id) begin
          errors++; $display("FAIL rnd_rsp c%0d got %h %b %b exp %h %b %b", cyc, rsp_data, rsp_flag, rsp_id, e_data, e_flag, e_id);
        end
      end
      if (!(outst && cyc == acc_cyc + 1)) begin
        checks++;
        if (flags0 !== ctx[0] || flags1 !== ctx[1]) begin
          errors++; $display("FAIL rnd_flags c%0d got %b %b exp %b %b", cyc, flags0, flags1, ctx[0], ctx[1]);
        end
      end
      acc = !outst || (exp_rv && rsp_ready);
      if (req_valid == 2'b11) g = (m_last == 0) ? 1 : 0;
      else                    g = req_valid[1] ? 1 : 0;
      exp_rr = (acc && req_valid != 2'b00) ? (2'b01 << g) : 2'b00;
      checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, req_ready, exp_rr); end
      if (exp_rv && rsp_ready) outst = 0;
      if (exp_rr != 2'b00) begin
        res = alu_fn(req_op[g*3 +: 3], req_in1[g*16 +: 16], req_in2[g*16 +: 16], ctx[g]);
        if (req_setflg[g]) ctx[g] = res[18:16];
        e_data  = res[15:0];
        e_flag  = res[18:16];
        e_id    = (g == 1);
        outst   = 1;
        acc_cyc = cyc;
        m_last  = g;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_in1    = '0;
    req_in2    = '0;
    req_op     = '0;
    req_setflg = '0;
    rsp_ready  = 1'b1;
    test_reset();
    test_add_overflow();
    test_arbitration();
    test_stall();
    test_setflg0();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
